memory_bus_controller: RTL and testbench
========================================

// Module: memory_bus_controller
// PURPOSE
// - Memory-side endpoint of the MemoryBus request/response channel. Takes one request at a time
//   from the request side and services it against an internal word array.
// - Each access has a fixed, configurable latency. Read data returns to the original requester
//   as a bus_read_response packet on the response side. Writes are fire-and-forget.
// PARAMETERS
// - MEM_WORDS       1024  array depth in words; must be a power of two
// - ACCESS_LATENCY  2     cycles from accept to array access; must be >= 1
// PORTS
// - clk           in   1                     system clock
// - reset_n       in   1                     asynchronous reset, active-low
// - req_busy      in   1                     request slot holds a packet
// - req_data      in   $bits(BusPacket)      request packet; valid while req_busy=1
// - req_accept    out  1                     1-cycle pulse: packet taken, requester clears req_busy
// - rsp_busy      in   1                     response slot occupied, not yet consumed
// - rsp_send      out  1                     1-cycle pulse: rsp_data valid, response slot gets set
// - rsp_data      out  $bits(BusPacket)      response packet
// - stat_reads    out  32                    only with MEM_CTRL_STATS_EN
// - stat_writes   out  32                    only with MEM_CTRL_STATS_EN
// BEHAVIOUR
// - Reset: one clock (clk), asynchronous active-low reset (reset_n).
//   - Asserting reset_n=0 sets state IDLE and clears req_accept, rsp_send, rsp_data,
//     the latency counter and the stat counters.
//   - Array contents are not reset.
// - Array index is address[$clog2(MEM_WORDS)-1:0]. Upper address bits are ignored, so
//   addresses alias modulo MEM_WORDS.
// - FSM state IDLE:
//   - If req_busy=1 in cycle T: pulse req_accept in T, latch req_data, load cnt=ACCESS_LATENCY-1,
//     go to WAIT.
// - FSM state WAIT:
//   - If cnt!=0: decrement cnt.
//   - If cnt==0 and type is bus_write_data: write payload to the array on this edge, go to IDLE.
//   - If cnt==0 and type is bus_read_data: capture the array word, go to RESP.
//   - If cnt==0 and the type is anything else (e.g. bus_read_response): discard, go to IDLE.
// - FSM state RESP:
//   - If rsp_busy=0: pulse rsp_send, drive rsp_data={bus_read_response, latched source, addr 0,
//     read word}, go to IDLE.
//   - If rsp_busy=1: hold in RESP; rsp_send stays 0 and rsp_data stays stable.
// - Latency, for a read accepted in cycle T:
//   - rsp_send fires at T+ACCESS_LATENCY+1 at the earliest.
//   - Each cycle rsp_busy=1 adds one cycle.
//   - A write is committed on the edge ending cycle T+ACCESS_LATENCY.
// - Single outstanding request:
//   - req_accept is never asserted outside IDLE.
//   - A new request arriving during WAIT or RESP waits in the request slot.
// - The IDLE state entered after rsp_send, or after a write commits, may accept in its first cycle.
//   Back-to-back writes are therefore spaced ACCESS_LATENCY+1 cycles apart.
// - Read after write to the same address returns the new data, because the write commits before
//   the next accept.
// - req_busy dropping while not in IDLE has no effect. The latched packet is authoritative.
// - Reset mid-operation: the in-flight request is abandoned.
//   - A pending write is not committed.
//   - No response is sent.
// CONFIGURATION
// - MEM_CTRL_STATS_EN defined:
//   - stat_reads increments on every rsp_send; stat_writes increments on every write commit.
//   - Both are 32-bit counters that wrap 0xFFFF_FFFF->0.
// - MEM_CTRL_STATS_EN undefined: the ports and counters are absent. Behaviour is otherwise identical.
// STRUCTURE
// - Shared package (bus_pkg), used by both ends of the bus: memory_address_t, bus_packet_payload_t,
//   BusID, the bus packet type enum (bus_read_data, bus_write_data, bus_read_response),
//   the BusPacket struct and create_bus_packet().
// - Local to this module: the FSM state enum.
// - One sub-module, mem_ctrl_sram: a single-port synchronous word array with write enable,
//   MEM_WORDS deep.
// TESTING
// - Read, latency 2: preload [0x10]=0xDEADBEEF; request read addr 0x10 src 3 at T
//   -> req_accept@T; rsp_send@T+3 with rsp_data={read_response, 3, 0, 0xDEADBEEF}.
// - Write then read: write 0x20<=0x12345678, then read 0x20 -> response payload 0x12345678;
//   rsp_send never pulses for the write.
// - Backpressure: rsp_busy=1 for 5 cycles at RESP -> rsp_send delayed 5 cycles, rsp_data stable
//   throughout, no req_accept during the hold.
// - Aliasing / illegal type: read addr MEM_WORDS+4 returns the word at 4; a bus_read_response
//   request is accepted and dropped, with no array change and no response.
// - Reset mid-op: assert reset_n=0 one cycle after accepting write 0x30<=0xAA
//   -> a later read of 0x30 returns the old value; all outputs are 0 during reset.
// - STATS_EN: 3 reads + 2 writes -> stat_reads=3, stat_writes=2; force stat_reads=0xFFFFFFFF,
//   one read -> 0.

Source files
------------

// File: rtl/bus_pkg.sv
// MemoryBus types shared by both ends of the request/response channel.
package bus_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned PAYLOAD_W = 32;
    localparam int unsigned ID_W      = 4;

    typedef logic [ADDR_W-1:0]    memory_address_t;
    typedef logic [PAYLOAD_W-1:0] bus_packet_payload_t;
    typedef logic [ID_W-1:0]      BusID;

    typedef enum logic [1:0] {
        bus_read_data     = 2'd0,
        bus_write_data    = 2'd1,
        bus_read_response = 2'd2
    } bus_packet_type_t;

    typedef struct packed {
        bus_packet_type_t    ptype;
        BusID                source;
        memory_address_t     address;
        bus_packet_payload_t payload;
    } BusPacket;

    function automatic BusPacket create_bus_packet(
        input bus_packet_type_t    ptype,
        input BusID                source,
        input memory_address_t     address,
        input bus_packet_payload_t payload
    );
        BusPacket p;
        p.ptype   = ptype;
        p.source  = source;
        p.address = address;
        p.payload = payload;
        return p;
    endfunction

endpackage

// File: rtl/mem_ctrl_sram.sv
// Single-port word array: synchronous write, combinational read of the addressed word.
module mem_ctrl_sram
    import bus_pkg::*;
#(
    parameter int unsigned WORDS  = 1024,
    parameter int unsigned ADDR_W = $clog2(WORDS)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  bus_packet_payload_t wdata,
    output bus_packet_payload_t rdata
);

    bus_packet_payload_t mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/memory_bus_controller.sv
// Memory-side MemoryBus endpoint: one request at a time, fixed access latency, read responses.
// Optional request statistics are enabled by defining MEM_CTRL_STATS_EN.
module memory_bus_controller
    import bus_pkg::*;
#(
    parameter int unsigned MEM_WORDS      = 1024,
    parameter int unsigned ACCESS_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_busy,
    input  BusPacket    req_data,
    output logic        req_accept,
    input  logic        rsp_busy,
    output logic        rsp_send,
`ifdef MEM_CTRL_STATS_EN
    output logic [31:0] stat_reads,
    output logic [31:0] stat_writes,
`endif
    output BusPacket    rsp_data
);

    localparam int unsigned AW    = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
    localparam memory_address_t ADDR_MASK = ADDR_W'(MEM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state, state_next;
    BusPacket            pkt, pkt_next;
    BusPacket            rsp_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    bus_packet_payload_t mem_rdata;

    // Upper address bits are dropped so accesses alias modulo MEM_WORDS.
    assign mem_addr = AW'(pkt.address & ADDR_MASK);

    mem_ctrl_sram #(
        .WORDS  (MEM_WORDS),
        .ADDR_W (AW)
    ) u_sram (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (pkt.payload),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            pkt      <= '0;
            cnt      <= '0;
            rsp_data <= '0;
        end else begin
            state    <= state_next;
            pkt      <= pkt_next;
            cnt      <= cnt_next;
            rsp_data <= rsp_next;
        end
    end

    always_comb begin
        state_next = state;
        pkt_next   = pkt;
        cnt_next   = cnt;
        rsp_next   = rsp_data;
        req_accept = 1'b0;
        rsp_send   = 1'b0;
        mem_we     = 1'b0;
        unique case (state)
            IDLE: begin
                // Accept is gated so it stays low while reset is held.
                if (req_busy && reset_n) begin
                    req_accept = 1'b1;
                    pkt_next   = req_data;
                    cnt_next   = CNT_W'(ACCESS_LATENCY - 1);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    state_next = IDLE;
                    if (pkt.ptype == bus_write_data) begin
                        mem_we = 1'b1;
                    end else if (pkt.ptype == bus_read_data) begin
                        rsp_next   = create_bus_packet(bus_read_response, pkt.source,
                                                       '0, mem_rdata);
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
                if (!rsp_busy) begin
                    rsp_send   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef MEM_CTRL_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_reads  <= '0;
            stat_writes <= '0;
        end else begin
            if (rsp_send) begin
                stat_reads <= stat_reads + 32'd1;
            end
            if (mem_we) begin
                stat_writes <= stat_writes + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_memory_bus_controller.sv
// Directed self-checking bench for memory_bus_controller (latency 2, 1024 words).
module tb_memory_bus_controller;
    import bus_pkg::*;

    localparam int unsigned LAT   = 2;
    localparam int unsigned WORDS = 1024;

    logic     clk = 1'b0;
    logic     reset_n;
    logic     req_busy;
    BusPacket req_data;
    logic     req_accept;
    logic     rsp_busy;
    logic     rsp_send;
    BusPacket rsp_data;
`ifdef MEM_CTRL_STATS_EN
    logic [31:0] stat_reads;
    logic [31:0] stat_writes;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_bus_controller #(
        .MEM_WORDS      (WORDS),
        .ACCESS_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_busy   (req_busy),
        .req_data   (req_data),
        .req_accept (req_accept),
        .rsp_busy   (rsp_busy),
        .rsp_send   (rsp_send),
`ifdef MEM_CTRL_STATS_EN
        .stat_reads (stat_reads),
        .stat_writes(stat_writes),
`endif
        .rsp_data   (rsp_data)
    );

    // Present a request at the current negedge (cycle T); return at negedge T+1 with busy cleared.
    task automatic issue(input bus_packet_type_t t, input BusID s, input memory_address_t a,
                         input bus_packet_payload_t p, output logic acc);
        req_data = create_bus_packet(t, s, a, p);
        req_busy = 1'b1;
        #1 acc = req_accept;
        @(negedge clk);
        req_busy = 1'b0;
    endtask

    // From negedge T+1, count cycles after T until rsp_send; -1 on timeout.
    task automatic wait_rsp(output int n, output BusPacket d);
        n = 1;
        #1;
        while (rsp_send !== 1'b1 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (rsp_send !== 1'b1) n = -1;
        d = rsp_data;
        @(negedge clk);
    endtask

    task automatic do_write(input memory_address_t a, input bus_packet_payload_t p,
                            output logic acc, output logic sent);
        sent = 1'b0;
        issue(bus_write_data, 4'd0, a, p, acc);
        for (int i = 0; i < int'(LAT); i++) begin
            #1 sent = sent | rsp_send;
            @(negedge clk);
        end
    endtask

    task automatic do_read(input BusID s, input memory_address_t a,
                           output logic acc, output int n, output BusPacket d);
        issue(bus_read_data, s, a, 32'h0, acc);
        wait_rsp(n, d);
    endtask

    task automatic test_reset;
        reset_n  = 1'b0;
        req_busy = 1'b1;
        rsp_busy = 1'b0;
        req_data = create_bus_packet(bus_read_data, 4'd1, 32'h0, 32'h0);
        #1;
        checks++; if (req_accept !== 1'b0) begin errors++; $display("FAIL reset_accept: got %b want 0", req_accept); end
        checks++; if (rsp_send !== 1'b0) begin errors++; $display("FAIL reset_send: got %b want 0", rsp_send); end
        checks++; if (rsp_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", rsp_data); end
        @(negedge clk);
        @(negedge clk);
        req_busy = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_latency;
        logic acc, sent;
        int n;
        BusPacket d;
        do_write(32'h10, 32'hDEADBEEF, acc, sent);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL preload_accept: got %b want 1", acc); end
        checks++; if (sent !== 1'b0) begin errors++; $display("FAIL preload_no_rsp: got %b want 0", sent); end
        do_read(4'd3, 32'h10, acc, n, d);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL read_accept: got %b want 1", acc); end
        checks++; if (n !== 3) begin errors++; $display("FAIL read_latency: got %0d want 3", n); end
        checks++; if (d !== create_bus_packet(bus_read_response, 4'd3, 32'h0, 32'hDEADBEEF)) begin
            errors++; $display("FAIL read_data: got %h want %h", d,
                               create_bus_packet(bus_read_response, 4'd3, 32'h0, 32'hDEADBEEF));
        end
    endtask

    task automatic test_write_read;
        logic acc, sent;
        int n;
        BusPacket d;
        do_write(32'h20, 32'h12345678, acc, sent);
        checks++; if (sent !== 1'b0) begin errors++; $display("FAIL write_no_rsp: got %b want 0", sent); end
        do_read(4'd5, 32'h20, acc, n, d);
        checks++; if (d.payload !== 32'h12345678) begin errors++; $display("FAIL wr_rd_payload: got %h want 12345678", d.payload); end
        checks++; if (d.source !== 4'd5) begin errors++; $display("FAIL wr_rd_source: got %0d want 5", d.source); end
    endtask

    task automatic test_back_to_back;
        logic acc;
        int n;
        BusPacket d;
        logic exp_acc [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        req_busy = 1'b1;
        req_data = create_bus_packet(bus_write_data, 4'd0, 32'h50, 32'h11111111);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) req_data = create_bus_packet(bus_write_data, 4'd0, 32'h54, 32'h22222222);
            #1;
            checks++; if (req_accept !== exp_acc[i]) begin errors++; $display("FAIL b2b_accept_%0d: got %b want %b", i, req_accept, exp_acc[i]); end
            @(negedge clk);
        end
        req_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        do_read(4'd2, 32'h54, acc, n, d);
        checks++; if (d.payload !== 32'h22222222) begin errors++; $display("FAIL b2b_rd_second: got %h want 22222222", d.payload); end
        do_read(4'd2, 32'h50, acc, n, d);
        checks++; if (d.payload !== 32'h11111111) begin errors++; $display("FAIL b2b_rd_first: got %h want 11111111", d.payload); end
    endtask

    task automatic test_backpressure;
        logic acc, sent;
        int n;
        BusPacket d;
        BusPacket exp_rsp;
        exp_rsp = create_bus_packet(bus_read_response, 4'd7, 32'h0, 32'hCAFEF00D);
        do_write(32'h40, 32'hCAFEF00D, acc, sent);
        rsp_busy = 1'b1;
        issue(bus_read_data, 4'd7, 32'h40, 32'h0, acc);
        // A second request waits in the slot for the whole hold.
        req_data = create_bus_packet(bus_read_data, 4'd2, 32'h40, 32'h0);
        req_busy = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            #1;
            checks++; if (rsp_send !== 1'b0 || req_accept !== 1'b0) begin
                errors++; $display("FAIL bp_hold_T%0d: send %b accept %b want 0 0", t, rsp_send, req_accept);
            end
            if (t >= 3) begin
                checks++; if (rsp_data !== exp_rsp) begin errors++; $display("FAIL bp_stable_T%0d: got %h want %h", t, rsp_data, exp_rsp); end
            end
            @(negedge clk);
        end
        rsp_busy = 1'b0;
        #1;
        checks++; if (rsp_send !== 1'b1 || req_accept !== 1'b0) begin
            errors++; $display("FAIL bp_release: send %b accept %b want 1 0", rsp_send, req_accept);
        end
        checks++; if (rsp_data !== exp_rsp) begin errors++; $display("FAIL bp_data: got %h want %h", rsp_data, exp_rsp); end
        @(negedge clk);
        #1;
        checks++; if (req_accept !== 1'b1) begin errors++; $display("FAIL bp_next_accept: got %b want 1", req_accept); end
        @(negedge clk);
        req_busy = 1'b0;
        wait_rsp(n, d);
        checks++; if (n !== 3 || d.source !== 4'd2) begin errors++; $display("FAIL bp_next_rsp: lat %0d src %0d want 3 2", n, d.source); end
    endtask

    task automatic test_alias_illegal;
        logic acc, sent;
        int n;
        BusPacket d;
        do_write(32'h4, 32'h44444444, acc, sent);
        do_read(4'd1, 32'(WORDS + 4), acc, n, d);
        checks++; if (d.payload !== 32'h44444444) begin errors++; $display("FAIL alias_read: got %h want 44444444", d.payload); end
        issue(bus_read_response, 4'd1, 32'h4, 32'h99999999, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL illegal_accept: got %b want 1", acc); end
        sent = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 sent = sent | rsp_send;
            @(negedge clk);
        end
        checks++; if (sent !== 1'b0) begin errors++; $display("FAIL illegal_no_rsp: got %b want 0", sent); end
        do_read(4'd1, 32'h4, acc, n, d);
        checks++; if (d.payload !== 32'h44444444) begin errors++; $display("FAIL illegal_no_write: got %h want 44444444", d.payload); end
    endtask

    task automatic test_reset_midop;
        logic acc, sent;
        int n;
        BusPacket d;
        do_write(32'h30, 32'h55, acc, sent);
        do_read(4'd6, 32'h30, acc, n, d);
        issue(bus_write_data, 4'd0, 32'h30, 32'hAA, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL midop_accept: got %b want 1", acc); end
        reset_n  = 1'b0;
        req_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (req_accept !== 1'b0 || rsp_send !== 1'b0 || rsp_data !== '0) begin
                errors++; $display("FAIL midop_outputs_%0d: acc %b send %b data %h want 0 0 0", i, req_accept, rsp_send, rsp_data);
            end
            @(negedge clk);
        end
        req_busy = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);
        do_read(4'd6, 32'h30, acc, n, d);
        checks++; if (d.payload !== 32'h55) begin errors++; $display("FAIL midop_old_value: got %h want 55", d.payload); end
    endtask

`ifdef MEM_CTRL_STATS_EN
    task automatic test_stats;
        logic acc, sent;
        int n;
        BusPacket d;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_write(32'h60, 32'h1, acc, sent);
        do_write(32'h61, 32'h2, acc, sent);
        for (int i = 0; i < 3; i++) do_read(4'd1, 32'h60, acc, n, d);
        checks++; if (stat_reads !== 32'd3) begin errors++; $display("FAIL stat_reads: got %0d want 3", stat_reads); end
        checks++; if (stat_writes !== 32'd2) begin errors++; $display("FAIL stat_writes: got %0d want 2", stat_writes); end
        force dut.stat_reads = 32'hFFFF_FFFF;
        #1;
        release dut.stat_reads;
        do_read(4'd1, 32'h60, acc, n, d);
        checks++; if (stat_reads !== 32'd0) begin errors++; $display("FAIL stat_wrap: got %h want 0", stat_reads); end
    endtask
`endif

    initial begin
        test_reset;
        test_read_latency;
        test_write_read;
        test_back_to_back;
        test_backpressure;
        test_alias_illegal;
        test_reset_midop;
`ifdef MEM_CTRL_STATS_EN
        test_stats;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
